// File: rtl/op_pkg.sv
// op_pkg: shared constants for the operator_arbiter slice.
// Opcode encodings, FSM state encoding and the datapath word width.
package op_pkg;

    localparam int WORD_W = 16;

    localparam logic [1:0] OP_FIX_ADD = 2'b00;
    localparam logic [1:0] OP_FIX_MUL = 2'b01;
    localparam logic [1:0] OP_FLO_ADD = 2'b10;
    localparam logic [1:0] OP_FLO_MUL = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/operator_arbiter_if.sv
// operator_arbiter_if: request and result handshake bundle.
// res_prec_lost exists only when PRECISION_FLAG_EN is defined.
interface operator_arbiter_if;
    import op_pkg::*;

    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [1:0]        req_op0;
    logic [1:0]        req_op1;
    logic [WORD_W-1:0] req_a0;
    logic [WORD_W-1:0] req_a1;
    logic [WORD_W-1:0] req_b0;
    logic [WORD_W-1:0] req_b1;
    logic              res_valid;
    logic              res_ready;
    logic [WORD_W-1:0] res_data;
    logic              res_ovf;
    logic              res_id;
`ifdef PRECISION_FLAG_EN
    logic              res_prec_lost;
`endif

    modport master (
        output req_valid, req_op0, req_op1,
        output req_a0, req_a1, req_b0, req_b1,
        output res_ready,
        input  req_ready,
        input  res_valid, res_data, res_ovf, res_id
`ifdef PRECISION_FLAG_EN
        , input res_prec_lost
`endif
    );

    modport slave (
        input  req_valid, req_op0, req_op1,
        input  req_a0, req_a1, req_b0, req_b1,
        input  res_ready,
        output req_ready,
        output res_valid, res_data, res_ovf, res_id
`ifdef PRECISION_FLAG_EN
        , output res_prec_lost
`endif
    );

endinterface

// File: rtl/operator_bank.sv
// operator_bank: four combinational cores plus result/overflow mux.
// prec_lost_o exists only when PRECISION_FLAG_EN is defined.
module operator_bank
    import op_pkg::*;
(
    input  logic [WORD_W-1:0] a_i,
    input  logic [WORD_W-1:0] b_i,
    input  logic [1:0]        op_i,
    output logic [WORD_W-1:0] data_o,
    output logic              ovf_o
`ifdef PRECISION_FLAG_EN
    , output logic            prec_lost_o
`endif
);

    function automatic logic [16:0] fix_add(input logic [15:0] a,
                                            input logic [15:0] b);
        logic [15:0] s;
        s = a + b;
        return {(a[15] == b[15]) && (s[15] != a[15]), s};
    endfunction

    // Signed 8.8 product truncated back to 8.8: {prec, ovf, data}.
    function automatic logic [17:0] fix_mul(input logic [15:0] a,
                                            input logic [15:0] b);
        logic [31:0] p;
        p = {{16{a[15]}}, a} * {{16{b[15]}}, b};
        return {|p[7:0], p[31:23] != {9{p[31]}}, p[23:8]};
    endfunction

    function automatic logic [16:0] flo_mul(input logic [15:0] a,
                                            input logic [15:0] b);
        logic        s;
        logic [11:0] hi;
        logic [9:0]  lo_unused;
        logic [9:0]  m;
        int          e;
        s = a[15] ^ b[15];
        {hi, lo_unused} = {11'd0, 1'b1, a[9:0]} * {11'd0, 1'b1, b[9:0]};
        e = int'(a[14:10]) + int'(b[14:10]) - 15;
        m = hi[11] ? hi[10:1] : hi[9:0];
        if (hi[11]) e = e + 1;
        if (a[14:10] == 5'd0 || b[14:10] == 5'd0) return {1'b0, s, 15'd0};
        if (a[14:10] == 5'h1f || b[14:10] == 5'h1f || e >= 31)
            return {1'b1, s, 5'h1f, 10'd0};
        if (e <= 0) return {1'b0, s, 15'd0};
        return {1'b0, s, e[4:0], m};
    endfunction

    // Denormals flush to zero; rounding is truncation.
    function automatic logic [16:0] flo_add(input logic [15:0] a,
                                            input logic [15:0] b);
        logic [15:0] x;
        logic [15:0] y;
        logic [11:0] mx;
        logic [11:0] my;
        logic [11:0] sum;
        int          ex;
        int          d;
        if (a[14:0] >= b[14:0]) begin
            x = a;
            y = b;
        end else begin
            x = b;
            y = a;
        end
        mx = (x[14:10] == 5'd0) ? 12'd0 : {2'b01, x[9:0]};
        my = (y[14:10] == 5'd0) ? 12'd0 : {2'b01, y[9:0]};
        ex = int'(x[14:10]);
        d = ex - int'(y[14:10]);
        my = my >> d;
        sum = (x[15] == y[15]) ? mx + my : mx - my;
        if (sum[11]) begin
            sum = sum >> 1;
            ex = ex + 1;
        end
        for (int i = 0; i < 11; i++) begin
            if (sum != 12'd0 && !sum[10]) begin
                sum = sum << 1;
                ex = ex - 1;
            end
        end
        if (x[14:10] == 5'h1f || ex >= 31) return {1'b1, x[15], 5'h1f, 10'd0};
        if (sum == 12'd0 || ex <= 0) return 17'd0;
        return {1'b0, x[15], ex[4:0], sum[9:0]};
    endfunction

    logic [WORD_W:0]   r_xadd;
    logic [WORD_W+1:0] r_xmul;
    logic [WORD_W:0]   r_fadd;
    logic [WORD_W:0]   r_fmul;
    logic [WORD_W:0]   sel;

    assign r_xadd = fix_add(a_i, b_i);
    assign r_xmul = fix_mul(a_i, b_i);
    assign r_fadd = flo_add(a_i, b_i);
    assign r_fmul = flo_mul(a_i, b_i);

    always_comb begin
        sel = r_xadd;
        case (op_i)
            OP_FIX_MUL: sel = r_xmul[WORD_W:0];
            OP_FLO_ADD: sel = r_fadd;
            OP_FLO_MUL: sel = r_fmul;
            default:    sel = r_xadd;
        endcase
    end

    assign {ovf_o, data_o} = sel;

`ifdef PRECISION_FLAG_EN
    assign prec_lost_o = (op_i == OP_FIX_MUL) && r_xmul[WORD_W+1];
`else
    logic prec_unused;
    assign prec_unused = r_xmul[WORD_W+1];
`endif

endmodule

// File: rtl/operator_arbiter.sv
// operator_arbiter: round-robin two-port sequencer for the core bank.
// Optional res_prec_lost output under PRECISION_FLAG_EN.
module operator_arbiter
    import op_pkg::*;
#(
    parameter int EXEC_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    operator_arbiter_if.slave bus
);

    localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES - 1);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              last_q;
    logic              id_q;
    logic [1:0]        op_q;
    logic [WORD_W-1:0] a_q;
    logic [WORD_W-1:0] b_q;
    logic              res_valid_q;
    logic [WORD_W-1:0] res_data_q;
    logic              res_ovf_q;
    logic              res_id_q;

    logic              gnt;
    logic [1:0]        ready;
    logic              hs;
    logic              cap;
    logic              res_hs;
    logic [WORD_W-1:0] bank_data;
    logic              bank_ovf;

`ifdef PRECISION_FLAG_EN
    logic              res_prec_q;
    logic              bank_prec;
`endif

    operator_bank u_bank (
        .a_i    (a_q),
        .b_i    (b_q),
        .op_i   (op_q),
        .data_o (bank_data),
        .ovf_o  (bank_ovf)
`ifdef PRECISION_FLAG_EN
        , .prec_lost_o (bank_prec)
`endif
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: if (hs) begin
                state_d = S_EXEC;
                cnt_d   = CNT_LOAD;
            end
            S_EXEC: if (cnt_q == 4'd0) state_d = S_DONE;
                    else cnt_d = cnt_q - 4'd1;
            S_DONE: if (res_hs) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // On a tie the requester that did not win last time is granted.
    always_comb begin
        case (bus.req_valid)
            2'b10:   gnt = 1'b1;
            2'b11:   gnt = ~last_q;
            default: gnt = 1'b0;
        endcase
        ready = 2'b00;
        if (state_q == S_IDLE && bus.req_valid != 2'b00)
            ready = gnt ? 2'b10 : 2'b01;
        hs     = (bus.req_valid & ready) != 2'b00;
        cap    = (state_q == S_EXEC) && (cnt_q == 4'd0);
        res_hs = res_valid_q && bus.res_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q      <= 1'b1;
            id_q        <= 1'b0;
            op_q        <= OP_FIX_ADD;
            a_q         <= '0;
            b_q         <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_ovf_q   <= 1'b0;
            res_id_q    <= 1'b0;
`ifdef PRECISION_FLAG_EN
            res_prec_q  <= 1'b0;
`endif
        end else begin
            if (hs) begin
                last_q <= gnt;
                id_q   <= gnt;
                op_q   <= gnt ? bus.req_op1 : bus.req_op0;
                a_q    <= gnt ? bus.req_a1 : bus.req_a0;
                b_q    <= gnt ? bus.req_b1 : bus.req_b0;
            end
            if (cap) begin
                res_valid_q <= 1'b1;
                res_data_q  <= bank_data;
                res_ovf_q   <= bank_ovf;
                res_id_q    <= id_q;
`ifdef PRECISION_FLAG_EN
                res_prec_q  <= bank_prec;
`endif
            end else if (res_hs) begin
                res_valid_q <= 1'b0;
            end
        end
    end

    assign bus.req_ready = ready;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_ovf   = res_ovf_q;
    assign bus.res_id    = res_id_q;
`ifdef PRECISION_FLAG_EN
    assign bus.res_prec_lost = res_prec_q;
`endif

endmodule

// File: tb/tb_operator_arbiter.sv
// tb_operator_arbiter: vector table plus scoreboard for operator_arbiter.
// Checks res_prec_lost as well when PRECISION_FLAG_EN is defined.
module tb_operator_arbiter;
    import op_pkg::*;

    localparam int E = 2;

    typedef struct {
        logic        id;
        logic [1:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] d;
        logic        o;
        logic        p;
    } vec_t;

    typedef struct {
        logic [15:0] d;
        logic        o;
        logic        id;
        logic        p;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    bit   busy = 1'b0;
    exp_t sb[$];
    vec_t vt[13];

    always #5 clk = ~clk;

    operator_arbiter_if bus ();

    operator_arbiter #(.EXEC_CYCLES(E)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic tmo(input string name);
        total++;
        bad++;
        $display("FAIL %s: timeout got none want event", name);
    endtask

    always begin
        @(negedge clk);
        #2;
        if (!rst) begin
            chk("ready_both", 32'(bus.req_ready == 2'b11), 32'd0);
            if (busy) chk("ready_busy", 32'(bus.req_ready), 32'd0);
        end
    end

    task automatic drive(input logic id, input logic [1:0] op,
                         input logic [15:0] a, input logic [15:0] b);
        if (id) begin
            bus.req_op1 = op;
            bus.req_a1  = a;
            bus.req_b1  = b;
        end else begin
            bus.req_op0 = op;
            bus.req_a0  = a;
            bus.req_b0  = b;
        end
        bus.req_valid[id] = 1'b1;
    endtask

    task automatic wait_hs(output logic who, output bit ok);
        ok  = 1'b0;
        who = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            #1;
            if (bus.req_ready != 2'b00) begin
                who = bus.req_ready[1];
                @(posedge clk);
                #1;
                busy = 1'b1;
                ok   = 1'b1;
                break;
            end
        end
        if (!ok) tmo("handshake");
    endtask

    task automatic wait_res(output int lat, output bit ok);
        lat = 0;
        ok  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.res_valid) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
            lat = lat + 1;
        end
        if (!ok) tmo("res_valid");
    endtask

    task automatic check_res();
        exp_t e;
        if (sb.size() == 0) begin
            tmo("scoreboard_empty");
        end else begin
            e = sb.pop_front();
            chk("res_data", 32'(bus.res_data), 32'(e.d));
            chk("res_ovf", 32'(bus.res_ovf), 32'(e.o));
            chk("res_id", 32'(bus.res_id), 32'(e.id));
`ifdef PRECISION_FLAG_EN
            chk("res_prec", 32'(bus.res_prec_lost), 32'(e.p));
`endif
        end
    endtask

    task automatic run_op(input logic exp_id, input exp_t e, input bit keep);
        logic who;
        bit   ok;
        int   lat;
        wait_hs(who, ok);
        if (!keep) bus.req_valid = 2'b00;
        if (ok) begin
            chk("grant", 32'(who), 32'(exp_id));
            sb.push_back(e);
            wait_res(lat, ok);
            chk("latency", 32'(lat), 32'(E));
            if (ok) check_res();
            @(posedge clk);
            #1;
            busy = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    initial begin
        logic last_m;
        logic g;
        logic who;
        bit   ok;
        int   lat;

        vt[0]  = '{1'b0, OP_FIX_ADD, 16'd27,   16'd42,   16'd69,   1'b0, 1'b0};
        vt[1]  = '{1'b1, OP_FLO_ADD, 16'h3C00, 16'h3C00, 16'h4000, 1'b0, 1'b0};
        vt[2]  = '{1'b1, OP_FLO_MUL, 16'h4000, 16'h4200, 16'h4600, 1'b0, 1'b0};
        vt[3]  = '{1'b1, OP_FLO_MUL, 16'h7800, 16'h7800, 16'h7C00, 1'b1, 1'b0};
        vt[4]  = '{1'b0, OP_FIX_MUL, 16'h0200, 16'h0300, 16'h0600, 1'b0, 1'b0};
        vt[5]  = '{1'b0, OP_FIX_ADD, 16'h7F00, 16'h0100, 16'h8000, 1'b1, 1'b0};
        vt[6]  = '{1'b1, OP_FIX_ADD, 16'hFF00, 16'h0080, 16'hFF80, 1'b0, 1'b0};
        vt[7]  = '{1'b0, OP_FIX_MUL, 16'hFE00, 16'h0180, 16'hFD00, 1'b0, 1'b0};
        vt[8]  = '{1'b1, OP_FIX_MUL, 16'h4000, 16'h0400, 16'h0000, 1'b1, 1'b0};
        vt[9]  = '{1'b0, OP_FIX_MUL, 16'h0101, 16'h0101, 16'h0102, 1'b0, 1'b1};
        vt[10] = '{1'b0, OP_FLO_ADD, 16'h4200, 16'hBC00, 16'h4000, 1'b0, 1'b0};
        vt[11] = '{1'b1, OP_FLO_MUL, 16'hC000, 16'h3800, 16'hBC00, 1'b0, 1'b0};
        vt[12] = '{1'b0, OP_FLO_ADD, 16'h7BFF, 16'h7BFF, 16'h7C00, 1'b1, 1'b0};

        bus.req_valid = 2'b00;
        bus.req_op0   = 2'b00;
        bus.req_op1   = 2'b00;
        bus.req_a0    = 16'd0;
        bus.req_a1    = 16'd0;
        bus.req_b0    = 16'd0;
        bus.req_b1    = 16'd0;
        bus.res_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_valid", 32'(bus.res_valid), 32'd0);
        chk("rst_data", 32'(bus.res_data), 32'd0);
        chk("rst_ovf_id", 32'({bus.res_ovf, bus.res_id}), 32'd0);
        chk("rst_ready", 32'(bus.req_ready), 32'd0);
        bus.req_valid = 2'b10;
        #1;
        chk("ready_only1", 32'(bus.req_ready), 32'd2);
        bus.req_valid = 2'b11;
        #1;
        chk("ready_tie", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 2'b00;

        // Both requesters valid from reset: grants alternate 0,1,0,1.
        drive(1'b0, OP_FIX_ADD, 16'h0100, 16'h0200);
        drive(1'b1, OP_FIX_ADD, 16'h0500, 16'h0100);
        last_m = 1'b1;
        for (int k = 0; k < 4; k++) begin
            g = ~last_m;
            run_op(g, '{g ? 16'h0600 : 16'h0300, 1'b0, g, 1'b0}, 1'b1);
            last_m = g;
        end
        bus.req_valid = 2'b00;

        for (int i = 0; i < 13; i++) begin
            drive(vt[i].id, vt[i].op, vt[i].a, vt[i].b);
            run_op(vt[i].id, '{vt[i].d, vt[i].o, vt[i].id, vt[i].p}, 1'b0);
        end

        // Backpressure with a second request pending on requester 0.
        bus.res_ready = 1'b0;
        drive(1'b0, OP_FIX_ADD, 16'h0300, 16'h0400);
        wait_hs(who, ok);
        chk("bp_grant", 32'(who), 32'd0);
        sb.push_back('{16'h0700, 1'b0, 1'b0, 1'b0});
        wait_res(lat, ok);
        chk("bp_latency", 32'(lat), 32'(E));
        check_res();
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_valid", 32'(bus.res_valid), 32'd1);
            chk("bp_data", 32'(bus.res_data), 32'h0700);
            chk("bp_ready", 32'(bus.req_ready), 32'd0);
        end
        @(negedge clk);
        bus.res_ready = 1'b1;
        #1;
        chk("bp_ready_pre", 32'(bus.req_ready), 32'd0);
        @(posedge clk);
        #1;
        busy = 1'b0;
        chk("bp_valid_drop", 32'(bus.res_valid), 32'd0);
        chk("bp_ready_post", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 2'b00;

        // Reset one cycle after a handshake on requester 0.
        drive(1'b0, OP_FIX_ADD, 16'h0100, 16'h0100);
        wait_hs(who, ok);
        bus.req_valid = 2'b00;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst  = 1'b0;
        busy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("mid_rst_valid", 32'(bus.res_valid), 32'd0);
            chk("mid_rst_out", 32'({bus.res_data, bus.res_ovf, bus.res_id}), 32'd0);
            @(posedge clk);
            #1;
        end

        // last_grant is back to 1, so requester 0 wins the tie.
        drive(1'b0, OP_FIX_ADD, 16'h0200, 16'h0300);
        drive(1'b1, OP_FIX_ADD, 16'h0900, 16'h0100);
        run_op(1'b0, '{16'h0500, 1'b0, 1'b0, 1'b0}, 1'b0);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
